// File: rtl/video_line_fetch.sv
// Double-buffered line buffer: the renderer fills one bank while the other is shown to the composite stage.
// Optional border colour for blank regions is enabled with VIDEO_LINE_FETCH_BORDER_EN.
module video_line_fetch #(
    parameter int H_PIXELS = 640,
    parameter int H_REPEAT = 2,
    parameter int V_LINES  = 240,
    parameter int DATA_W   = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              next_frame,
    input  logic              next_line,
    input  logic              next_pixel,
    output logic              fill_req,
    output logic [8:0]        fill_line,
    input  logic              wr_en,
    input  logic [9:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              fill_done,
`ifdef VIDEO_LINE_FETCH_BORDER_EN
    input  logic [DATA_W-1:0] border_rgb,
`endif
    output logic [DATA_W-1:0] palette_rgb_data,
    output logic              underrun
);
    localparam int RW = (H_REPEAT > 1) ? $clog2(H_REPEAT) : 1;
    localparam logic [9:0]    V_END    = 10'(V_LINES);
    localparam logic [9:0]    H_LAST   = 10'(H_PIXELS - 1);
    localparam logic [9:0]    H_COUNT  = 10'(H_PIXELS);
    localparam logic [RW-1:0] REP_LAST = RW'(H_REPEAT - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state_q, state_d;
    logic              disp_bank;
    logic              ready;
    logic              init_done;
    logic              blank_line;
    logic [8:0]        line_cnt;
    logic [9:0]        rd_addr;
    logic [RW-1:0]     rep_cnt;
    logic [DATA_W-1:0] blank_rgb;
    logic [DATA_W-1:0] rd_data;
    logic              wr_ok;

    logic              line_start;
    logic [9:0]        tgt_line;
    logic [8:0]        succ_line;
    logic              ready_eff;
    logic              go_idle;
    logic              do_swap;
    logic              do_under;

    logic [DATA_W-1:0] bank0 [H_PIXELS];
    logic [DATA_W-1:0] bank1 [H_PIXELS];

`ifdef VIDEO_LINE_FETCH_BORDER_EN
    assign blank_rgb = border_rgb;
`else
    assign blank_rgb = '0;
`endif

    // Writes always land in the bank that is not on screen.
    assign wr_ok   = rst_n & wr_en & fill_req & (wr_addr < H_COUNT);
    assign rd_data = disp_bank ? bank1[rd_addr] : bank0[rd_addr];

    always_ff @(posedge clk) begin
        if (wr_ok && disp_bank)  bank0[wr_addr] <= wr_data;
        if (wr_ok && !disp_bank) bank1[wr_addr] <= wr_data;
    end

    // A fill_done arriving with the line start counts as already complete.
    always_comb begin
        state_d    = state_q;
        line_start = next_frame | (next_line & (state_q == ACTIVE));
        tgt_line   = next_frame ? 10'd0 : ({1'b0, line_cnt} + 10'd1);
        succ_line  = ((tgt_line + 10'd1) == V_END) ? 9'd0 : (tgt_line[8:0] + 9'd1);
        ready_eff  = ready | (fill_done & fill_req);
        go_idle    = 1'b0;
        do_swap    = 1'b0;
        do_under   = 1'b0;
        if (line_start) begin
            if (tgt_line == V_END) begin
                go_idle = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = ACTIVE;
                if (ready_eff && ({1'b0, fill_line} == tgt_line)) do_swap = 1'b1;
                else                                               do_under = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_bank        <= 1'b0;
            ready            <= 1'b0;
            init_done        <= 1'b0;
            blank_line       <= 1'b0;
            line_cnt         <= '0;
            rd_addr          <= '0;
            rep_cnt          <= '0;
            fill_req         <= 1'b0;
            fill_line        <= '0;
            underrun         <= 1'b0;
            palette_rgb_data <= '0;
        end else begin
            init_done <= 1'b1;
            underrun  <= do_under;

            if (!init_done) begin
                fill_req  <= 1'b1;
                fill_line <= '0;
            end
            if (fill_done && fill_req) begin
                ready    <= 1'b1;
                fill_req <= 1'b0;
            end

            if (line_start) begin
                rd_addr <= '0;
                rep_cnt <= '0;
            end else if (next_pixel) begin
                if (rep_cnt == REP_LAST) begin
                    rep_cnt <= '0;
                    if (rd_addr != H_LAST) rd_addr <= rd_addr + 10'd1;
                end else begin
                    rep_cnt <= rep_cnt + RW'(1);
                end
            end

            if (do_swap || do_under) begin
                ready      <= 1'b0;
                fill_req   <= 1'b1;
                fill_line  <= succ_line;
                line_cnt   <= tgt_line[8:0];
                blank_line <= do_under;
                if (do_swap) disp_bank <= ~disp_bank;
            end

            // Leaving the field keeps a line-0 prefill that is done or still in progress.
            if (go_idle && !((fill_line == 9'd0) && (ready_eff || fill_req))) begin
                ready     <= 1'b0;
                fill_req  <= 1'b1;
                fill_line <= '0;
            end

            if (next_pixel && (state_q == ACTIVE) && !blank_line)
                palette_rgb_data <= rd_data;
            else
                palette_rgb_data <= blank_rgb;
        end
    end

endmodule

// File: tb/tb_video_line_fetch.sv
// Bench for video_line_fetch: directed line fills and displays, pixel stream scored against an expected queue.
module tb_video_line_fetch;

`ifdef VIDEO_LINE_FETCH_BORDER_EN
    localparam logic [11:0] BLANK = 12'hF00;
`else
    localparam logic [11:0] BLANK = 12'h000;
`endif

    logic        clk;
    logic        rst_n;
    logic        next_frame;
    logic        next_line;
    logic        next_pixel;
    logic        fill_req;
    logic [8:0]  fill_line;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [11:0] wr_data;
    logic        fill_done;
    logic [11:0] palette_rgb_data;
    logic        underrun;
`ifdef VIDEO_LINE_FETCH_BORDER_EN
    logic [11:0] border_rgb;
`endif

    logic [11:0] exp_q[$];
    int          total;
    int          bad;

    video_line_fetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .next_frame       (next_frame),
        .next_line        (next_line),
        .next_pixel       (next_pixel),
        .fill_req         (fill_req),
        .fill_line        (fill_line),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .fill_done        (fill_done),
`ifdef VIDEO_LINE_FETCH_BORDER_EN
        .border_rgb       (border_rgb),
`endif
        .palette_rgb_data (palette_rgb_data),
        .underrun         (underrun)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one clock; e is the pixel expected to be registered at this edge
    task automatic tick(input logic [11:0] e);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    // monitor: the registered output is valid by the falling edge
    always @(negedge clk) begin : monitor
        logic [11:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pixel", {20'd0, palette_rgb_data}, {20'd0, e});
        end
    end

    // driver tasks
    task automatic fill_full(input logic [11:0] base);
        for (int i = 0; i < 640; i++) begin
            wr_en   = 1'b1;
            wr_addr = 10'(i);
            wr_data = 12'(i) + base;
            tick(BLANK);
        end
        wr_en = 1'b0;
    endtask

    task automatic show_line(input logic [11:0] base, input logic blank);
        next_pixel = 1'b1;
        for (int k = 0; k < 1280; k++) begin
            if (blank) tick(BLANK);
            else       tick(12'(k / 2) + base);
        end
        next_pixel = 1'b0;
        tick(BLANK);
    endtask

    // line 3 pattern: pixels 0..3 overwritten, rest still holds line 0 data (value = addr)
    task automatic show_patched_line;
        next_pixel = 1'b1;
        for (int k = 0; k < 1280; k++) begin
            if (k / 2 < 4) tick(12'hA00 + 12'(k / 2));
            else           tick(12'(k / 2));
        end
        next_pixel = 1'b0;
        tick(BLANK);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        next_frame = 1'b0;
        next_line  = 1'b0;
        next_pixel = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        fill_done  = 1'b0;
`ifdef VIDEO_LINE_FETCH_BORDER_EN
        border_rgb = 12'hF00;
`endif

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pixel", {20'd0, palette_rgb_data}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_fill_req", {31'd0, fill_req}, 32'd0);
        check("rst_fill_line", {23'd0, fill_line}, 32'd0);

        rst_n = 1'b1;
        tick(BLANK);
        check("init_fill_req", {31'd0, fill_req}, 32'd1);
        check("init_fill_line", {23'd0, fill_line}, 32'd0);
        check("init_underrun", {31'd0, underrun}, 32'd0);

        // line 0: value = addr, shown from next_frame
        fill_full(12'h000);
        fill_done = 1'b1;
        tick(BLANK);
        fill_done = 1'b0;
        check("l0_done_fill_req", {31'd0, fill_req}, 32'd0);
        next_frame = 1'b1;
        next_line  = 1'b1;
        tick(BLANK);
        next_frame = 1'b0;
        next_line  = 1'b0;
        check("l0_underrun", {31'd0, underrun}, 32'd0);
        check("l0_fill_req", {31'd0, fill_req}, 32'd1);
        check("l0_fill_line", {23'd0, fill_line}, 32'd1);
        show_line(12'h000, 1'b0);

        // line 1 never filled: underrun, blank line
        next_line = 1'b1;
        tick(BLANK);
        next_line = 1'b0;
        check("l1_underrun", {31'd0, underrun}, 32'd1);
        check("l1_fill_line", {23'd0, fill_line}, 32'd2);
        check("l1_fill_req", {31'd0, fill_req}, 32'd1);
        next_pixel = 1'b1;
        tick(BLANK);
        check("l1_underrun_pulse", {31'd0, underrun}, 32'd0);
        for (int k = 1; k < 1280; k++) tick(BLANK);
        next_pixel = 1'b0;
        tick(BLANK);

        // line 2: fill_done coincides with next_line
        fill_full(12'h100);
        fill_done = 1'b1;
        next_line = 1'b1;
        tick(BLANK);
        fill_done = 1'b0;
        next_line = 1'b0;
        check("l2_underrun", {31'd0, underrun}, 32'd0);
        check("l2_fill_line", {23'd0, fill_line}, 32'd3);
        check("l2_fill_req", {31'd0, fill_req}, 32'd1);
        show_line(12'h100, 1'b0);

        // line 3: partial fill into the bank that held line 0, plus ignored writes
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_addr = 10'(i);
            wr_data = 12'hA00 + 12'(i);
            tick(BLANK);
        end
        wr_addr = 10'd700;
        wr_data = 12'hCCC;
        tick(BLANK);
        wr_en     = 1'b0;
        fill_done = 1'b1;
        tick(BLANK);
        fill_done = 1'b0;
        check("l3_done_fill_req", {31'd0, fill_req}, 32'd0);
        wr_en   = 1'b1;
        wr_addr = 10'd4;
        wr_data = 12'hBBB;
        tick(BLANK);
        wr_en     = 1'b0;
        fill_done = 1'b1;
        tick(BLANK);
        fill_done = 1'b0;
        next_line = 1'b1;
        tick(BLANK);
        next_line = 1'b0;
        check("l3_underrun", {31'd0, underrun}, 32'd0);
        check("l3_fill_line", {23'd0, fill_line}, 32'd4);
        show_patched_line();

        // lines 4..239: short fills, strobes only
        for (int l = 4; l < 240; l++) begin
            wr_en   = 1'b1;
            wr_addr = 10'd0;
            wr_data = 12'(l);
            tick(BLANK);
            wr_addr = 10'd1;
            tick(BLANK);
            wr_en     = 1'b0;
            fill_done = 1'b1;
            tick(BLANK);
            fill_done = 1'b0;
            next_line = 1'b1;
            tick(BLANK);
            next_line = 1'b0;
            check("sweep_underrun", {31'd0, underrun}, 32'd0);
            check("sweep_fill_line", {23'd0, fill_line}, (l == 239) ? 32'd0 : 32'(l + 1));
        end

        // prefill line 0 of the next field, then run off the end of the field
        fill_full(12'h300);
        fill_done = 1'b1;
        tick(BLANK);
        fill_done = 1'b0;
        next_line = 1'b1;
        tick(BLANK);
        next_line = 1'b0;
        check("eof_underrun", {31'd0, underrun}, 32'd0);
        check("eof_fill_req", {31'd0, fill_req}, 32'd0);
        check("eof_fill_line", {23'd0, fill_line}, 32'd0);
        next_pixel = 1'b1;
        repeat (8) tick(BLANK);
        next_pixel = 1'b0;
        next_line  = 1'b1;
        tick(BLANK);
        next_line = 1'b0;
        check("idle_line_underrun", {31'd0, underrun}, 32'd0);
        check("idle_line_fill_req", {31'd0, fill_req}, 32'd0);

        // new field shows the prefilled line 0
        next_frame = 1'b1;
        next_line  = 1'b1;
        tick(BLANK);
        next_frame = 1'b0;
        next_line  = 1'b0;
        check("f2_underrun", {31'd0, underrun}, 32'd0);
        check("f2_fill_line", {23'd0, fill_line}, 32'd1);
        check("f2_fill_req", {31'd0, fill_req}, 32'd1);
        show_line(12'h300, 1'b0);

        // another underrun line
        next_line = 1'b1;
        tick(BLANK);
        next_line = 1'b0;
        check("f2l1_underrun", {31'd0, underrun}, 32'd1);
        check("f2l1_fill_line", {23'd0, fill_line}, 32'd2);
        next_pixel = 1'b1;
        repeat (16) tick(BLANK);
        next_pixel = 1'b0;
        tick(BLANK);

        // final report
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_line_fetch.md
Name: video_line_fetch

Overview:
Double-buffered line buffer that feeds palette_rgb_data to the composite timing/modulator stage. It consumes that stage's next_frame, next_line and next_pixel strobes. An upstream renderer fills one bank through a write port while the other bank is displayed. Each pixel is repeated H_REPEAT clocks, so 640 pixels span the 1280-clock active line.

Parameters:
H_PIXELS, 640, pixels per displayed line
H_REPEAT, 2, clocks each pixel is held (H_PIXELS*H_REPEAT = active clocks)
V_LINES, 240, active lines per field
DATA_W, 12, pixel width (4:4:4 RGB)

Ports:
clk  in  1  video clock (same as composite stage)
rst_n  in  1  synchronous active-low reset
next_frame  in  1  first active line of a field starts (coincides with next_line)
next_line  in  1  one-clock strobe, clock before each line's active region
next_pixel  in  1  high during active clocks of a line
fill_req  out  1  level; renderer must fill the free bank with line fill_line
fill_line  out  9  line index to render, 0..V_LINES-1
wr_en  in  1  write strobe into the free bank
wr_addr  in  10  pixel index
wr_data  in  DATA_W  pixel value
fill_done  in  1  one-clock strobe; free bank complete
palette_rgb_data  out  DATA_W  pixel to composite stage
underrun  out  1  one-clock pulse; line started without a ready fill

Behaviour:
- Reset (rst_n low at clk edge):
  - palette_rgb_data=0, underrun=0, fill_req=0, fill_line=0.
  - State IDLE, display bank=0, ready=0.
  - Bank RAM contents are not cleared.
  - First clock after reset release: fill_req=1, fill_line=0 (prefill line 0 into bank 1).
  - Reset mid-fill abandons the fill.
- States:
  - IDLE (between fields; next_line ignored).
  - ACTIVE (line counter 0..V_LINES-1).
- Fill handshake:
  - While fill_req=1, wr_en writes wr_data to free bank[wr_addr].
  - wr_en with fill_req=0, or wr_addr>=H_PIXELS, is ignored.
  - fill_done with fill_req=1: ready=1, fill_req=0 next clock.
  - fill_done with fill_req=0 is ignored.
- Line start (next_frame in any state, or next_line in ACTIVE):
  - Target line L = 0 on next_frame, else current+1.
  - If L==V_LINES: go IDLE; request fill of line 0; no underrun.
  - Else if ready=1 and pending fill_line==L:
    - swap banks, ready=0.
    - next clock: fill_req=1, fill_line=(L+1==V_LINES)?0:L+1.
  - Else:
    - underrun pulses next clock; line L displays black; display bank unchanged.
    - Any pending fill is abandoned (ready=0).
    - Fill reissued for L+1 (or 0 if L+1==V_LINES).
  - next_frame forces ACTIVE, line 0.
- fill_done and line start in the same clock: the fill counts as completed before the swap decision.
- Pixel read:
  - Read address and repeat counter reset at line start.
  - On each next_pixel clock, bank[display][rd_addr] is read; rd_addr increments after H_REPEAT clocks, saturating at H_PIXELS-1.
  - palette_rgb_data is registered: value appears 1 clock after the corresponding next_pixel clock.
  - palette_rgb_data=0 when the previous clock had next_pixel=0, state IDLE, or an underrun line.
- Widths: rd_addr 10 bits; repeat counter ceil(log2(H_REPEAT)) bits (min 1); line counter 9 bits.

Optional Feature:
- VIDEO_LINE_FETCH_BORDER_EN defined:
  - Adds input border_rgb [DATA_W-1:0].
  - IDLE, underrun lines, and non-active clocks of ACTIVE lines output border_rgb instead of 0.
  - border_rgb is sampled every clock.
- Undefined: port absent; those cases output 0.

Test Plan:
- Reset release -> fill_req=1, fill_line=0 next clock; palette_rgb_data=0; underrun=0.
- Fill 640 pixels with value=addr[11:0], fill_done, then next_frame + 1280 next_pixel clocks -> output 0x000,0x000,0x001,0x001,...,0x27F,0x27F, each 1 clock after next_pixel; fill_req=1 with fill_line=1 after swap.
- Line 1 not filled before next_line -> underrun pulse; 1280 clocks of 0; fill_line=2; line 0 bank not overwritten.
- Fill lines 0..239 in turn -> after line 239 start, fill_line=0; 241st next_line leaves state IDLE with no underrun and output 0; next_frame displays the prefilled line 0.
- fill_done and next_line in the same clock -> swap occurs, no underrun; wr_en with fill_req=0 and wr_addr=700 leave bank contents unchanged.
- With VIDEO_LINE_FETCH_BORDER_EN, border_rgb=0xF00 -> IDLE and underrun lines output 0xF00; without the macro -> 0x000.
